// File: rtl/i2c_clk_ce_gen_pkg.sv
// Shared types and sizing helpers for the fabric clock-enable generator.
// State encoding, loss-counter width and counter width helper.
`timescale 1ns/1ps
package i2c_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } clk_state_e;

    localparam int LOCK_CNT_W = 8;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_clk_ce_gen_if.sv
// Bundle between the clock conditioner and its surroundings.
// master drives lock/enables/divisors, slave is the generator.
`timescale 1ns/1ps
interface i2c_clk_ce_gen_if
    import i2c_clk_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 16
);

    logic                    pll_lock;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic                    locked;
    logic                    fabric_resetn;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       clk_tgl;
    logic [LOCK_CNT_W-1:0]   lock_loss_cnt;

    modport master (
        output pll_lock, ch_en, div_val,
        input  locked, fabric_resetn, ce,
        input  clk_tgl, lock_loss_cnt
    );

    modport slave (
        input  pll_lock, ch_en, div_val,
        output locked, fabric_resetn, ce,
        output clk_tgl, lock_loss_cnt
    );

endinterface

// File: rtl/i2c_clk_ce_gen_div_ch.sv
// One clock-enable channel: down-counter, CE pulse and 50% toggle.
// The divisor is only sampled at terminal count, so no runt periods.
`timescale 1ns/1ps
module i2c_clk_div_ch #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    output logic             ce,
    output logic             clk_tgl
);

    logic [DIV_W-1:0] cnt;

    // Idle channels hold the divisor so the first period is full length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            ce      <= 1'b0;
            clk_tgl <= 1'b0;
        end else if (!run) begin
            cnt     <= div_val;
            ce      <= 1'b0;
            clk_tgl <= 1'b0;
        end else if (cnt == '0) begin
            cnt     <= div_val;
            ce      <= 1'b1;
            clk_tgl <= ~clk_tgl;
        end else begin
            cnt     <= cnt - 1'b1;
            ce      <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_clk_ce_gen.sv
// Fabric clock conditioner: filters PLL lock, sequences reset release
// and runs NUM_CH programmable clock-enable channels once in RUN.
`timescale 1ns/1ps
module i2c_clk_ce_gen
    import i2c_clk_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_FILTER = 64,
    parameter int RST_HOLD    = 16
) (
    input logic             PCLK,
    input logic             PRESETN,
    i2c_clk_ce_gen_if.slave bus
);

    localparam int FW = cnt_w(LOCK_FILTER);
    localparam int HW = cnt_w(RST_HOLD);
    localparam logic [FW-1:0] F_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] H_LAST = HW'(RST_HOLD - 1);

    logic                  lk_s1;
    logic                  lk;
    clk_state_e            state;
    logic [FW-1:0]         fcnt;
    logic [HW-1:0]         hcnt;
    logic                  locked_q;
    logic                  rstn_q;
    logic [LOCK_CNT_W-1:0] loss_q;
    logic [NUM_CH-1:0]     run;
    logic [NUM_CH-1:0]     ce_w;
    logic [NUM_CH-1:0]     tgl_w;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            lk_s1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            lk_s1 <= bus.pll_lock;
            lk    <= lk_s1;
        end
    end

    // Lock sequencer; outputs move on the same edge as the state.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state    <= WAIT_LOCK;
            fcnt     <= '0;
            hcnt     <= '0;
            locked_q <= 1'b0;
            rstn_q   <= 1'b0;
            loss_q   <= '0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= FILTER;
                        fcnt  <= '0;
                    end
                end
                FILTER: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                    end else if (fcnt == F_LAST) begin
                        state    <= HOLD;
                        hcnt     <= '0;
                        locked_q <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        locked_q <= 1'b0;
                    end else if (hcnt == H_LAST) begin
                        state  <= RUN;
                        rstn_q <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state    <= WAIT_LOCK;
                        locked_q <= 1'b0;
                        rstn_q   <= 1'b0;
                        if (loss_q != '1) begin
                            loss_q <= loss_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Gating on lk clears channels on the edge FABRIC_RESETN falls.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign run[i] = (state == RUN) & lk & bus.ch_en[i];

        i2c_clk_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk     (PCLK),
            .rst_n   (PRESETN),
            .run     (run[i]),
            .div_val (bus.div_val[i*DIV_W +: DIV_W]),
            .ce      (ce_w[i]),
            .clk_tgl (tgl_w[i])
        );
    end

    assign bus.locked        = locked_q;
    assign bus.fabric_resetn = rstn_q;
    assign bus.ce            = ce_w;
    assign bus.clk_tgl       = tgl_w;
    assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_i2c_clk_ce_gen.sv
// Bench for the fabric clock conditioner: lock timing, glitch refilter,
// channel cadence, divisor change, channel drop, lock-loss counting.
`timescale 1ns/1ps
module tb_i2c_clk_ce_gen;
    import i2c_clk_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;

    logic PCLK    = 1'b0;
    logic PRESETN = 1'b0;

    always #5 PCLK = ~PCLK;

    i2c_clk_ce_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    i2c_clk_ce_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_FILTER (64),
        .RST_HOLD    (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    string tag_q[$];
    int    exp_q[$];
    logic [3:0] cap [0:63];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input int obs);
        string t;
        int    e;
        if (exp_q.size() == 0) begin
            check("sb_empty", obs, -999);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, obs, e);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_div(input int ch, input int v);
        bus.div_val[ch*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.locked;
            1:       return bus.fabric_resetn;
            2:       return bus.ce[0];
            default: return bus.ce[1];
        endcase
    endfunction

    // Edges until the selected output is high; -1 if the budget runs out.
    task automatic wait_sig(input int sel, input int budget,
                            output int n, output int act);
        n   = 0;
        act = 0;
        do begin
            tick();
            n++;
            if (bus.ce != '0 || bus.clk_tgl != '0) act = 1;
        end while (!sig(sel) && n < budget);
        if (!sig(sel)) n = -1;
    endtask

    function automatic logic [3:0] cur();
        return {bus.clk_tgl[1], bus.clk_tgl[0], bus.ce[1], bus.ce[0]};
    endfunction

    task automatic capture(input int n);
        cap[0] = cur();
        for (int i = 1; i <= n; i++) begin
            tick();
            cap[i] = cur();
        end
    endtask

    function automatic int pos_of(input int b, input int n,
                                  input bit rise, input int k);
        int c = 0;
        for (int p = 1; p <= n; p++) begin
            if (cap[p][b] && (!rise || !cap[p-1][b])) begin
                if (c == k) return p;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int gap(input int b, input int n,
                               input bit rise, input int k);
        int a = pos_of(b, n, rise, k);
        int z = pos_of(b, n, rise, k + 1);
        return (a < 0 || z < 0) ? -1 : z - a;
    endfunction

    function automatic int cnt_hi(input int b, input int n);
        int c = 0;
        for (int p = 1; p <= n; p++) if (cap[p][b]) c++;
        return c;
    endfunction

    function automatic int cnt_chg(input int b, input int n);
        int c = 0;
        for (int p = 1; p <= n; p++) if (cap[p][b] != cap[p-1][b]) c++;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int act;
        int act1;

        bus.pll_lock = 1'b1;
        bus.ch_en    = 2'b11;
        bus.div_val  = '0;
        set_div(0, 3);
        set_div(1, 0);

        // Reset state
        PRESETN = 1'b0;
        repeat (5) tick();
        expect_val("rst_locked", 0);   observe(int'(bus.locked));
        expect_val("rst_resetn", 0);   observe(int'(bus.fabric_resetn));
        expect_val("rst_ce", 0);       observe(int'(bus.ce));
        expect_val("rst_tgl", 0);      observe(int'(bus.clk_tgl));
        expect_val("rst_loss", 0);     observe(int'(bus.lock_loss_cnt));

        // Lock and reset-release timing from reset release
        PRESETN = 1'b1;
        wait_sig(0, 200, n, act);
        act1 = act;
        expect_val("lock_rise", 67);   observe(n);
        wait_sig(1, 100, n, act);
        expect_val("hold_len", 16);    observe(n);
        expect_val("idle_ce", 0);      observe(act1 | act);

        // Lock glitch at filter count 40 forces a full refilter
        PRESETN = 1'b0;
        repeat (5) tick();
        PRESETN = 1'b1;
        repeat (43) tick();
        expect_val("filt_locked", 0);  observe(int'(bus.locked));
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        wait_sig(0, 300, n, act);
        expect_val("refilter", 111);   observe(44 + n);
        expect_val("glitch_loss", 0);  observe(int'(bus.lock_loss_cnt));
        wait_sig(1, 100, n, act);
        expect_val("hold_len2", 16);   observe(n);

        // Channel cadence: ch0 div 3, ch1 div 0
        capture(24);
        expect_val("ce0_first", 4);    observe(pos_of(0, 24, 0, 0));
        for (int k = 0; k < 5; k++) begin
            expect_val("ce0_per", 4);  observe(gap(0, 24, 0, k));
        end
        for (int k = 0; k < 2; k++) begin
            expect_val("tgl0_per", 8); observe(gap(2, 24, 1, k));
        end
        expect_val("tgl0_duty", 12);   observe(cnt_hi(2, 24));
        expect_val("ce1_hi", 24);      observe(cnt_hi(1, 24));
        expect_val("tgl1_chg", 24);    observe(cnt_chg(3, 24));

        // Divisor change mid-period waits for terminal count
        set_div(0, 9);
        wait_sig(2, 20, n, act);
        expect_val("ce0_sync", 4);     observe(n);
        wait_sig(2, 30, n, act);
        expect_val("ce0_div9", 10);    observe(n);
        repeat (3) tick();
        set_div(0, 4);
        wait_sig(2, 30, n, act);
        expect_val("ce0_nochop", 10);  observe(3 + n);
        wait_sig(2, 30, n, act);
        expect_val("ce0_div4a", 5);    observe(n);
        wait_sig(2, 30, n, act);
        expect_val("ce0_div4b", 5);    observe(n);

        // Drop ch1 mid-period, ch0 keeps its cadence
        set_div(1, 6);
        wait_sig(3, 10, n, act);
        expect_val("ce1_sync", 1);     observe(n);
        wait_sig(3, 20, n, act);
        expect_val("ce1_div6", 7);     observe(n);
        repeat (2) tick();
        bus.ch_en = 2'b01;
        capture(15);
        expect_val("drop_ce1", 0);     observe(cnt_hi(1, 15));
        expect_val("drop_tgl1", 0);    observe(cnt_hi(3, 15));
        expect_val("drop_ce0a", 5);    observe(gap(0, 15, 0, 0));
        expect_val("drop_ce0b", 5);    observe(gap(0, 15, 0, 1));
        bus.ch_en = 2'b11;
        wait_sig(3, 30, n, act);
        expect_val("reen_ce1", 7);     observe(n);

        // Reset mid-period clears everything on the next edge
        tick();
        PRESETN = 1'b0;
        tick();
        expect_val("prst_ce", 0);      observe(int'(bus.ce));
        expect_val("prst_tgl", 0);     observe(int'(bus.clk_tgl));
        expect_val("prst_locked", 0);  observe(int'(bus.locked));
        expect_val("prst_resetn", 0);  observe(int'(bus.fabric_resetn));
        PRESETN = 1'b1;
        wait_sig(1, 200, n, act);
        expect_val("run_after_rst", 83); observe(n);

        // Repeated lock loss in RUN; counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b0;
            tick();
            bus.pll_lock = 1'b1;
            tick();
            if (i == 0) begin
                expect_val("loss_pre", 1); observe(int'(bus.locked));
            end
            tick();
            if (i == 0) begin
                expect_val("loss_locked", 0); observe(int'(bus.locked));
                expect_val("loss_resetn", 0); observe(int'(bus.fabric_resetn));
                expect_val("loss_ce", 0);     observe(int'(bus.ce));
                expect_val("loss_tgl", 0);    observe(int'(bus.clk_tgl));
                expect_val("loss_cnt1", 1);   observe(int'(bus.lock_loss_cnt));
            end
            if (i == 254) begin
                expect_val("loss_cnt255", 255);
                observe(int'(bus.lock_loss_cnt));
            end
            wait_sig(1, 200, n, act);
            expect_val("relock", 81);  observe(n);
        end
        expect_val("loss_sat", 255);   observe(int'(bus.lock_loss_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
